// File: rtl/cmp_minmax_seq.sv
// cmp_minmax_seq -- finds max/min (value and 0-based index) of a run of DEPTH
// unsigned samples using a single shared 4-bit magnitude comparator.
//
// Ports:
//   clk        system clock, all state changes on rising edge
//   rst_n      synchronous active-low reset
//   start      begin a run (only looked at in IDLE)
//   din        sample data
//   din_valid  din is valid
//   din_ready  block accepts din this cycle (WAIT only)
//   busy       run in progress (cycle after accepted start through DONE)
//   done       one-cycle pulse when the run completes
//   max_out    largest sample of the last run
//   min_out    smallest sample of the last run
//   max_idx    index of max_out
//   min_idx    index of min_out
//
// Build option: define CMP_TIE_LAST_EN to report the latest index of an equal
// extreme instead of the earliest. Cycle timing is the same in both builds.

// 4-bit magnitude comparator: 100 a>b, 001 a<b, 010 a==b.
module cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [2:0] code
);
  always_comb begin
    code = 3'b010;
    if (a > b)      code = 3'b100;
    else if (a < b) code = 3'b001;
  end
endmodule

module cmp_minmax_seq #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [3:0]       max_idx,
  output logic [3:0]       min_idx
);

  if (WIDTH != 4 || DEPTH < 2 || DEPTH > 16) begin : g_bad_param
    $error("cmp_minmax_seq: WIDTH must be 4 and DEPTH in 2..16");
  end

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b001;
`ifdef CMP_TIE_LAST_EN
  localparam logic [2:0] EQ = 3'b010;
`endif
  localparam logic [3:0] LAST = 4'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WAIT, CMP_MAX, CMP_MIN, DONE} state_t;

  state_t           state;
  logic [3:0]       count;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] cmp_b;
  logic [2:0]       code;

  // A side is always the captured sample; B side picks the running extreme
  // being challenged. Result is only consumed in CMP_MAX / CMP_MIN.
  assign cmp_b = (state == CMP_MIN) ? min_out : max_out;

  cmp4 u_cmp (
    .a    (s_reg),
    .b    (cmp_b),
    .code (code)
  );

  // Handshake/status outputs are pure state decodes: no din path to outputs.
  assign din_ready = (state == WAIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      s_reg   <= '0;
      max_out <= '0;
      min_out <= '0;
      max_idx <= '0;
      min_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT;
            count <= '0;
          end
        end
        WAIT: begin
          if (din_valid && din_ready) begin
            s_reg <= din;
            // First sample seeds both extremes; no compare needed.
            if (count == '0) begin
              max_out <= din;
              min_out <= din;
              max_idx <= '0;
              min_idx <= '0;
              count   <= 4'd1;
            end else begin
              state <= CMP_MAX;
            end
          end
        end
        CMP_MAX: begin
          if (code == GT) begin
            max_out <= s_reg;
            max_idx <= count;
          end
`ifdef CMP_TIE_LAST_EN
          else if (code == EQ) begin
            max_idx <= count;
          end
`endif
          state <= CMP_MIN;
        end
        CMP_MIN: begin
          if (code == LT) begin
            min_out <= s_reg;
            min_idx <= count;
          end
`ifdef CMP_TIE_LAST_EN
          else if (code == EQ) begin
            min_idx <= count;
          end
`endif
          if (count == LAST) begin
            state <= DONE;
          end else begin
            count <= count + 4'd1;
            state <= WAIT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
